// File: rtl/audio_stream_core.sv
`default_nettype none
// ============================================================================
// Module   : audio_stream_core
// Purpose  : Handshaked stereo audio path between the CODEC input and output
//            interfaces. Each input pair is captured, processed (L/R swap,
//            mono downmix, arithmetic-shift attenuation, mute) and buffered in
//            a small output FIFO that decouples the input and output
//            handshakes.
// Ports    : CLOCK_50/reset          - clock, synchronous active-high reset
//            audio_in_available/L/R  - CODEC input pair and its ready flag
//            read_audio_in           - one-cycle acknowledge of an input pair
//            audio_out_allowed       - CODEC can accept an output pair
//            write_audio_out/L/R     - one-cycle write strobe + held output pair
//            mute/atten/swap_lr/mono - processing controls, latched per sample
//            fifo_level              - current FIFO occupancy
//            peak_clr/peak_L/peak_R  - peak meters (AUDIO_STREAM_PEAK_EN only)
// Options  : define AUDIO_STREAM_PEAK_EN to add the peak meters.
// Revision : 1.0 - initial release
// ============================================================================
module audio_stream_core #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ATTEN_W    = 4
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          audio_in_available,
    input  logic [DATA_W-1:0]             audio_in_L,
    input  logic [DATA_W-1:0]             audio_in_R,
    output logic                          read_audio_in,
    input  logic                          audio_out_allowed,
    output logic                          write_audio_out,
    output logic [DATA_W-1:0]             audio_out_L,
    output logic [DATA_W-1:0]             audio_out_R,
    input  logic                          mute,
    input  logic [ATTEN_W-1:0]            atten,
    input  logic                          swap_lr,
    input  logic                          mono,
`ifdef AUDIO_STREAM_PEAK_EN
    input  logic                          peak_clr,
    output logic [DATA_W-1:0]             peak_L,
    output logic [DATA_W-1:0]             peak_R,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IN_IDLE    = 2'd0,
        IN_REQ     = 2'd1,
        IN_CAPTURE = 2'd2
    } in_state_t;

    typedef enum logic [0:0] {
        OUT_IDLE  = 1'b0,
        OUT_WRITE = 1'b1
    } out_state_t;

    in_state_t                 in_state_q,  in_state_d;
    out_state_t                out_state_q, out_state_d;

    logic signed [DATA_W-1:0]  cap_l_q, cap_l_d, cap_r_q, cap_r_d;
    logic                      cap_mute_q, cap_mute_d;
    logic                      cap_swap_q, cap_swap_d;
    logic                      cap_mono_q, cap_mono_d;
    logic [ATTEN_W-1:0]        cap_atten_q, cap_atten_d;

    logic [DATA_W-1:0]         fifo_l_q [FIFO_DEPTH];
    logic [DATA_W-1:0]         fifo_l_d [FIFO_DEPTH];
    logic [DATA_W-1:0]         fifo_r_q [FIFO_DEPTH];
    logic [DATA_W-1:0]         fifo_r_d [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]          level_q, level_d;

    logic [DATA_W-1:0]         out_l_q, out_l_d, out_r_q, out_r_d;

    logic                      push, pop, credit_ok;
    logic [LVL_W:0]            committed;
    logic signed [DATA_W-1:0]  sw_l, sw_r, mix_l, mix_r, proc_l, proc_r;
    logic signed [DATA_W:0]    sum;

    // ------------------------------------------------------------------
    // Processing of the captured pair: swap -> mono -> attenuate -> mute
    // ------------------------------------------------------------------
    always_comb begin
        sw_l  = cap_swap_q ? cap_r_q : cap_l_q;
        sw_r  = cap_swap_q ? cap_l_q : cap_r_q;
        // One extra bit so the L+R sum cannot overflow before halving.
        sum   = {sw_l[DATA_W-1], sw_l} + {sw_r[DATA_W-1], sw_r};
        mix_l = sw_l;
        mix_r = sw_r;
        if (cap_mono_q) begin
            mix_l = DATA_W'(sum >>> 1);
            mix_r = DATA_W'(sum >>> 1);
        end
        // Signed operand: shifts in sign bits, so large shifts settle at 0 / -1.
        proc_l = mix_l >>> cap_atten_q;
        proc_r = mix_r >>> cap_atten_q;
        if (cap_mute_q) begin
            proc_l = '0;
            proc_r = '0;
        end
    end

    // ------------------------------------------------------------------
    // Input FSM. A read is only issued when every sample already in the
    // pipe still has a FIFO slot reserved, so the FIFO can never overflow.
    // ------------------------------------------------------------------
    always_comb begin
        committed   = {1'b0, level_q}
                    + (LVL_W+1)'(in_state_q == IN_CAPTURE)
                    + (LVL_W+1)'(in_state_q == IN_REQ);
        credit_ok   = committed < (LVL_W+1)'(FIFO_DEPTH);
        push        = (in_state_q == IN_CAPTURE);

        in_state_d  = in_state_q;
        cap_l_d     = cap_l_q;
        cap_r_d     = cap_r_q;
        cap_mute_d  = cap_mute_q;
        cap_swap_d  = cap_swap_q;
        cap_mono_d  = cap_mono_q;
        cap_atten_d = cap_atten_q;

        case (in_state_q)
            IN_IDLE: begin
                if (audio_in_available && credit_ok) begin
                    in_state_d = IN_REQ;
                end
            end
            IN_REQ: begin
                // Latch regardless of audio_in_available: the read is committed.
                in_state_d  = IN_CAPTURE;
                cap_l_d     = audio_in_L;
                cap_r_d     = audio_in_R;
                cap_mute_d  = mute;
                cap_swap_d  = swap_lr;
                cap_mono_d  = mono;
                cap_atten_d = atten;
            end
            IN_CAPTURE: begin
                in_state_d = IN_IDLE;
            end
            default: begin
                in_state_d = IN_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output FSM and FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        pop         = (out_state_q == OUT_IDLE) && (level_q != '0) && audio_out_allowed;
        out_state_d = pop ? OUT_WRITE : OUT_IDLE;
        out_l_d     = pop ? fifo_l_q[rd_ptr_q] : out_l_q;
        out_r_d     = pop ? fifo_r_q[rd_ptr_q] : out_r_q;

        fifo_l_d    = fifo_l_q;
        fifo_r_d    = fifo_r_q;
        if (push) begin
            fifo_l_d[wr_ptr_q] = proc_l;
            fifo_r_d[wr_ptr_q] = proc_r;
        end
        // FIFO_DEPTH is a power of two, so pointers wrap naturally.
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            in_state_q  <= IN_IDLE;
            out_state_q <= OUT_IDLE;
            cap_l_q     <= '0;
            cap_r_q     <= '0;
            cap_mute_q  <= 1'b0;
            cap_swap_q  <= 1'b0;
            cap_mono_q  <= 1'b0;
            cap_atten_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            cap_l_q     <= cap_l_d;
            cap_r_q     <= cap_r_d;
            cap_mute_q  <= cap_mute_d;
            cap_swap_q  <= cap_swap_d;
            cap_mono_q  <= cap_mono_d;
            cap_atten_q <= cap_atten_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
        end
    end

    // Storage needs no reset: occupancy is governed by the pointers.
    always_ff @(posedge CLOCK_50) begin
        fifo_l_q <= fifo_l_d;
        fifo_r_q <= fifo_r_d;
    end

    assign read_audio_in   = (in_state_q == IN_REQ);
    assign write_audio_out = (out_state_q == OUT_WRITE);
    assign audio_out_L     = out_l_q;
    assign audio_out_R     = out_r_q;
    assign fifo_level      = level_q;

`ifdef AUDIO_STREAM_PEAK_EN
    logic [DATA_W-1:0] peak_l_q, peak_l_d, peak_r_q, peak_r_d;

    // Magnitude with the most-negative value clamped to the largest positive.
    function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] x);
        if (!x[DATA_W-1]) begin
            return x;
        end else if (x == {1'b1, {(DATA_W-1){1'b0}}}) begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            return -x;
        end
    endfunction

    always_comb begin
        peak_l_d = peak_l_q;
        peak_r_d = peak_r_q;
        if (peak_clr) begin
            peak_l_d = '0;
            peak_r_d = '0;
        end else if (push) begin
            if (mag(proc_l) > peak_l_q) peak_l_d = mag(proc_l);
            if (mag(proc_r) > peak_r_q) peak_r_d = mag(proc_r);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end else begin
            peak_l_q <= peak_l_d;
            peak_r_q <= peak_r_d;
        end
    end

    assign peak_L = peak_l_q;
    assign peak_R = peak_r_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_stream_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_stream_core
// Purpose  : Self-checking bench for audio_stream_core. A transaction-level
//            reference model computes each expected output pair from the
//            input pair and controls present when the DUT acknowledges it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_stream_core;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        audio_in_available = 1'b0;
    logic [31:0] audio_in_L = '0;
    logic [31:0] audio_in_R = '0;
    logic        read_audio_in;
    logic        audio_out_allowed = 1'b0;
    logic        write_audio_out;
    logic [31:0] audio_out_L;
    logic [31:0] audio_out_R;
    logic        mute = 1'b0;
    logic [3:0]  atten = 4'd0;
    logic        swap_lr = 1'b0;
    logic        mono = 1'b0;
    logic [2:0]  fifo_level;
`ifdef AUDIO_STREAM_PEAK_EN
    logic [31:0] peak_L, peak_R;
`endif

    audio_stream_core #(.DATA_W(32), .FIFO_DEPTH(4), .ATTEN_W(4)) dut (
        .CLOCK_50          (clk),
        .reset             (reset),
        .audio_in_available(audio_in_available),
        .audio_in_L        (audio_in_L),
        .audio_in_R        (audio_in_R),
        .read_audio_in     (read_audio_in),
        .audio_out_allowed (audio_out_allowed),
        .write_audio_out   (write_audio_out),
        .audio_out_L       (audio_out_L),
        .audio_out_R       (audio_out_R),
        .mute              (mute),
        .atten             (atten),
        .swap_lr           (swap_lr),
        .mono              (mono),
`ifdef AUDIO_STREAM_PEAK_EN
        .peak_clr          (1'b0),
        .peak_L            (peak_L),
        .peak_R            (peak_R),
`endif
        .fifo_level        (fifo_level)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          n_reads = 0;
    bit          rnd_mode = 1'b0;
    logic [31:0] stim_l[$], stim_r[$];
    logic [31:0] exp_l[$], exp_r[$];
    logic [31:0] seen_l[$];
    logic [31:0] last_l = '0, last_r = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // floor(x / 2^k) by plain integer division
    function automatic longint floor_shift(input longint x, input int k);
        longint d;
        d = longint'(1) << k;
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    function automatic void model(input logic [31:0] il, input logic [31:0] ir,
                                  input bit sw, input bit mo, input bit mu, input int at,
                                  output logic [31:0] ol, output logic [31:0] orr);
        longint a, b, s;
        a = sw ? longint'($signed(ir)) : longint'($signed(il));
        b = sw ? longint'($signed(il)) : longint'($signed(ir));
        if (mo) begin
            s = a + b;
            a = floor_shift(s, 1);
            b = a;
        end
        a = floor_shift(a, at);
        b = floor_shift(b, at);
        if (mu) begin
            a = 0;
            b = 0;
        end
        ol  = a[31:0];
        orr = b[31:0];
    endfunction

    task automatic drive();
        if (rnd_mode) begin
            mute              = ($urandom_range(7) == 0);
            atten             = ($urandom_range(2) == 0) ? 4'($urandom_range(15)) : 4'd0;
            swap_lr           = 1'($urandom_range(1));
            mono              = ($urandom_range(3) == 0);
            audio_out_allowed = ($urandom_range(2) != 0);
        end
        audio_in_available = (stim_l.size() != 0) && (!rnd_mode || $urandom_range(4) != 0);
        if (stim_l.size() != 0) begin
            audio_in_L = stim_l[0];
            audio_in_R = stim_r[0];
        end else begin
            audio_in_L = $urandom;
            audio_in_R = $urandom;
        end
    endtask

    task automatic load(input logic [31:0] l, input logic [31:0] r);
        stim_l.push_back(l);
        stim_r.push_back(r);
        drive();
    endtask

    // One clock: predict the capture, advance, then check write / hold.
    task automatic tick();
        bit          rd;
        logic [31:0] el, er;
        rd = (read_audio_in === 1'b1) && !reset;
        if (rd) begin
            model(audio_in_L, audio_in_R, swap_lr, mono, mute, int'(atten), el, er);
            exp_l.push_back(el);
            exp_r.push_back(er);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            exp_l.delete();
            exp_r.delete();
            last_l = '0;
            last_r = '0;
        end else begin
            if (rd) begin
                void'(stim_l.pop_front());
                void'(stim_r.pop_front());
                n_reads++;
            end
            if (write_audio_out === 1'b1) begin
                if (exp_l.size() == 0) begin
                    check("write_when_empty", 64'(write_audio_out), 64'd0);
                end else begin
                    check("out_L", audio_out_L, exp_l[0]);
                    check("out_R", audio_out_R, exp_r[0]);
                    void'(exp_l.pop_front());
                    void'(exp_r.pop_front());
                end
                seen_l.push_back(audio_out_L);
                last_l = audio_out_L;
                last_r = audio_out_R;
            end else begin
                check("hold_L", audio_out_L, last_l);
                check("hold_R", audio_out_R, last_r);
            end
        end
        drive();
    endtask

    task automatic wait_rd(input string tag);
        int n = 0;
        while (read_audio_in !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check(tag, 64'(read_audio_in), 64'd1);
    endtask

    task automatic wait_wr(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (write_audio_out !== 1'b1 && n < 60);
        check(tag, 64'(write_audio_out), 64'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_l.size() != 0 || stim_l.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        check(tag, 64'(exp_l.size() + stim_l.size()), 64'd0);
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, "_rd"},  64'(read_audio_in),   64'd0);
        check({tag, "_wr"},  64'(write_audio_out), 64'd0);
        check({tag, "_L"},   audio_out_L,          64'd0);
        check({tag, "_R"},   audio_out_R,          64'd0);
        check({tag, "_lvl"}, 64'(fifo_level),      64'd0);
    endtask

    initial begin
        int c_rd;
        int r0;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check_zero_state("reset");

        // Passthrough and latency
        audio_out_allowed = 1'b1;
        load(32'd1000, 32'hFFFF_FC18);               // 1000 / -1000
        wait_rd("pt_rd");
        c_rd = cyc;
        wait_wr("pt_wr");
        check("pt_latency", 64'(cyc - c_rd), 64'd3);
        check("pt_L", audio_out_L, 32'd1000);
        check("pt_R", audio_out_R, 32'hFFFF_FC18);

        // Mute, attenuation
        mute = 1'b1;
        load(32'd5000, 32'd5000);
        wait_wr("mute_wr");
        check("mute_L", audio_out_L, 32'd0);
        check("mute_R", audio_out_R, 32'd0);
        mute  = 1'b0;
        atten = 4'd2;
        load(32'd5000, 32'hFFFF_EC78);               // 5000 / -5000
        wait_wr("att2_wr");
        check("att2_L", audio_out_L, 32'd1250);
        check("att2_R", audio_out_R, 32'hFFFF_FB1E); // -1250
        atten = 4'd15;
        load(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_wr("att15_wr");
        check("att15_L", audio_out_L, 32'hFFFF_FFFF);
        check("att15_R", audio_out_R, 32'hFFFF_FFFF);
        atten = 4'd0;

        // Swap and mono
        swap_lr = 1'b1;
        load(32'd7, 32'd9);
        wait_wr("swap_wr");
        check("swap_L", audio_out_L, 32'd9);
        check("swap_R", audio_out_R, 32'd7);
        swap_lr = 1'b0;
        mono    = 1'b1;
        load(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        wait_wr("mono_wr");
        check("mono_L", audio_out_L, 32'h7FFF_FFFF);
        check("mono_R", audio_out_R, 32'h7FFF_FFFF);
        mono = 1'b0;

        // Output valid with the strobe, then held
        load(32'hDEAD_BEEF, 32'h0BAD_F00D);
        wait_wr("tm_wr");
        check("tm_L", audio_out_L, 32'hDEAD_BEEF);
        repeat (3) tick();
        check("tm_hold", audio_out_L, 32'hDEAD_BEEF);

        // Backpressure
        audio_out_allowed = 1'b0;
        seen_l.delete();
        r0 = n_reads;
        for (int i = 1; i <= 6; i++) load(32'(i), 32'(i + 100));
        repeat (40) tick();
        check("bp_reads", 64'(n_reads - r0), 64'd4);
        check("bp_level", 64'(fifo_level), 64'd4);
        check("bp_noread", 64'(read_audio_in), 64'd0);
        audio_out_allowed = 1'b1;
        drain("bp_drain");
        repeat (4) tick();
        check("bp_count", 64'(seen_l.size()), 64'd6);
        for (int i = 0; i < 6 && i < seen_l.size(); i++) begin
            check("bp_order", seen_l[i], 64'(i + 1));
        end

        // Reset mid-operation with two entries buffered and a read in flight
        audio_out_allowed = 1'b0;
        load(32'h111, 32'h1111);
        load(32'h222, 32'h2222);
        load(32'h333, 32'h3333);
        begin
            int n = 0;
            while (!(read_audio_in === 1'b1 && fifo_level == 3'd2) && n < 100) begin
                tick();
                n++;
            end
        end
        check("rst_setup", 64'(fifo_level), 64'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero_state("rst_mid");
        audio_out_allowed = 1'b1;
        wait_wr("rst_resume_wr");
        check("rst_resume_L", audio_out_L, 32'h333);
        check("rst_resume_R", audio_out_R, 32'h3333);

        // Randomized traffic against the model
        rnd_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (stim_l.size() < 3) load($urandom, $urandom);
            tick();
        end
        rnd_mode          = 1'b0;
        mute              = 1'b0;
        atten             = 4'd0;
        swap_lr           = 1'b0;
        mono              = 1'b0;
        audio_out_allowed = 1'b1;
        drain("rnd_drain");
        repeat (4) tick();
        check("rnd_level", 64'(fifo_level), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/audio_stream_core.md
Name: audio_stream_core

Overview:
- Parametrised successor of the single-sample audio passthrough path. Sits between the audio CODEC handshake interface (audio_in_available / read_audio_in, audio_out_allowed / write_audio_out) and the board switches.
- Adds a configurable sample width and an output FIFO that decouples the input and output handshakes.
- Adds per-sample processing: attenuation by arithmetic shift, L/R swap, mono downmix and mute.

Parameters:
- DATA_W, 32, sample width per channel in bits, signed two's complement.
- FIFO_DEPTH, 4, number of processed stereo sample pairs buffered; power of 2, minimum 2.
- ATTEN_W, 4, width of the attenuation shift control.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- audio_in_available  in  1  CODEC has an input sample pair ready.
- audio_in_L  in  DATA_W  signed left input sample.
- audio_in_R  in  DATA_W  signed right input sample.
- read_audio_in  out  1  one-cycle pulse; acknowledges and consumes an input pair.
- audio_out_allowed  in  1  CODEC can accept an output pair.
- write_audio_out  out  1  one-cycle pulse; presents an output pair.
- audio_out_L  out  DATA_W  registered left output sample.
- audio_out_R  out  DATA_W  registered right output sample.
- mute  in  1  force processed samples to 0.
- atten  in  ATTEN_W  arithmetic right-shift amount.
- swap_lr  in  1  exchange left and right channels.
- mono  in  1  both outputs carry the L/R average.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, applied at any time including mid-transfer:
  - read_audio_in, write_audio_out, audio_out_L/R and fifo_level all become 0.
  - The FIFO and the capture stage are emptied.
  - Any in-flight sample is discarded.
- Input FSM states:
  - IDLE -> REQ when audio_in_available=1 and (fifo_level + capture_valid + push_pending) < FIFO_DEPTH.
  - In REQ, read_audio_in=1 for exactly one cycle.
  - REQ -> CAPTURE: on the edge that ends REQ, audio_in_L/R and all control inputs are latched. Capture happens even if audio_in_available has dropped.
  - CAPTURE -> IDLE: the processed pair is pushed to the FIFO on the next edge.
  - Minimum spacing between read_audio_in pulses is 3 cycles.
- Processing, applied in this order to the latched values:
  1. swap_lr exchanges L and R.
  2. mono: both channels = (L+R)>>>1, computed at DATA_W+1 bits, so no overflow.
  3. Each channel = x >>> atten, sign-preserving. Large shifts saturate to 0 for positive inputs and to -1 for negative inputs.
  4. mute forces both channels to 0.
- Output FSM states:
  - OIDLE -> WRITE when FIFO is non-empty and audio_out_allowed=1.
  - On that edge the FIFO head is popped into audio_out_L/R, and write_audio_out=1 for one cycle.
  - audio_out_L/R are valid on the same cycle write_audio_out is high, and hold their value until the next pop.
  - WRITE -> OIDLE unconditionally. Minimum spacing between write pulses is 2 cycles.
- Latency, with an empty FIFO and audio_out_allowed held high: write_audio_out rises exactly 3 cycles after read_audio_in rises.
- FIFO:
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - No input read is issued while the credit check fails, so the FIFO never overflows and samples are never dropped.
  - No write is issued while the FIFO is empty.
- audio_out_allowed dropping while FIFO is non-empty: data is held and no write is issued. The input side continues until the FIFO is full.

Optional Feature:
- Macro: AUDIO_STREAM_PEAK_EN.
- With the macro defined:
  - Adds input peak_clr (1 bit) and outputs peak_L, peak_R (DATA_W each).
  - Each peak output holds the maximum absolute value of the processed samples pushed to the FIFO since reset or the last peak_clr pulse.
  - |most-negative| saturates to 2^(DATA_W-1)-1.
  - peak_clr takes priority over a same-cycle update.
- Without the macro: those ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Passthrough: in L=1000, R=-1000, all controls 0, both handshakes high -> one write pulse with out L=1000, R=-1000, 3 cycles after the read pulse.
- Mute plus atten: mute=1 with in 5000 -> out 0/0. Then mute=0, atten=2, in L=5000, R=-5000 -> out 1250/-1250. atten=15 with in -1 -> out -1.
- Swap/mono: swap_lr=1, in 7/9 -> out 9/7. mono=1, in 32'h7FFFFFFF/32'h7FFFFFFF -> out 7FFFFFFF on both channels (no overflow).
- Timing: in 32'hDEADBEEF -> audio_out_L === 32'hDEADBEEF on the exact cycle write_audio_out is high. Values are unchanged on the following cycles until the next write.
- Backpressure: audio_out_allowed=0, available held high, distinct samples 1..6 -> exactly 4 reads and fifo_level=4, then no further reads. Set allowed=1 -> outputs 1,2,3,4,5,6 in order with no loss or duplication.
- Reset mid-operation: assert reset for 1 cycle while read_audio_in=1 with 2 entries buffered -> all outputs 0 and fifo_level=0 on the next cycle. Traffic then resumes correctly.
